// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Downstream stage of the 32-tap FIR filter. Averages groups of DECIM =
// 2**DECIM_LOG2 accepted samples (accumulate-and-dump) and queues each average
// in a small FIFO that the next consumer drains through a valid/ready
// handshake. Upstream cannot be stalled, so a result that finds the FIFO full
// (and no pop on the same edge) is dropped and flagged on the sticky overflow.
//
// Optional build macro: FIR_DECIM_ROUND_EN
//   undefined : result = sum >> DECIM_LOG2 (truncation)
//   defined   : result = (sum + 2**(DECIM_LOG2-1)) >> DECIM_LOG2 (round half up)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   in_valid    in_data carries a filter output sample this cycle
//   in_data     filter output sample, unsigned
//   flush       synchronous discard of the partial accumulation
//   out_valid   FIFO holds at least one result
//   out_data    registered FIFO head
//   out_ready   consumer accepts the head
//   fifo_level  number of results stored
//   overflow    sticky: a result was dropped on a full FIFO
//   clr_ovf     synchronous clear of overflow (a same-edge drop wins)
//
// Output handshake: a result transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and out_data
// holds steady while out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module fir_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        clr_ovf
);

    localparam int ACC_W = DATA_WIDTH + DECIM_LOG2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Accumulator and phase
    logic [ACC_W-1:0]      acc;
    logic [DECIM_LOG2-1:0] phase;
    logic [ACC_W-1:0]      sum;
    logic [ACC_W-1:0]      sum_adj;
    logic [DATA_WIDTH-1:0] result;
    logic                  dump;

    // FIFO
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      level_after_pop;
    logic [LVL_W-1:0]      level_next;
    logic [DATA_WIDTH-1:0] head_next;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // ACC_W leaves DECIM_LOG2 bits of headroom, so a full group never wraps.
    assign sum = acc + ACC_W'(in_data);

`ifdef FIR_DECIM_ROUND_EN
    // Max sum + half LSB still shifts down to at most 2**DATA_WIDTH-1.
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (DECIM_LOG2 - 1);
    assign sum_adj = sum + HALF;
`else
    assign sum_adj = sum;
`endif

    assign result = DATA_WIDTH'(sum_adj >> DECIM_LOG2);

    // Last sample of a group; flush overrides it so nothing is pushed.
    assign dump = in_valid & ~flush & (&phase);

    assign out_valid  = (level != '0);
    assign fifo_level = level;
    assign pop        = out_valid & out_ready;

    // A full FIFO can still take the result if the head leaves on this edge.
    assign push = dump & ((level != LVL_FULL) | pop);
    assign drop = dump & (level == LVL_FULL) & ~pop;

    always_comb begin
        level_after_pop = level - LVL_W'(pop);
        level_next      = level_after_pop + LVL_W'(push);
        rd_ptr_next     = rd_ptr + PTR_W'(pop);
        head_next       = out_data;
        // Entries still stored after the pop were written on earlier edges,
        // so memory holds them; if nothing remains, the head can only be the
        // result being pushed right now.
        if (level_after_pop != '0) begin
            head_next = mem[rd_ptr_next];
        end else if (push) begin
            head_next = result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            phase <= '0;
        end else if (flush) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            if (&phase) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + DECIM_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_next;
            level    <= level_next;
            out_data <= head_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Self-checking bench for fir_decimator (DECIM=4, FIFO_DEPTH=8). Each group
// average is computed by the bench and queued in exp_q when the dump sample
// is driven; a negedge monitor pops and compares whenever the DUT transfers
// a result, and also tracks fifo_level and overflow against the bench's own
// bookkeeping. Honors FIR_DECIM_ROUND_EN like the design.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

    localparam int DW    = 16;
    localparam int DL    = 2;
    localparam int DECIM = 1 << DL;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_ovf   = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;
    logic          mon_en  = 1'b0;
    logic [DW-1:0] mon_exp;
    int            m_acc   = 0;
    int            m_phase = 0;

    fir_decimator #(
        .DATA_WIDTH(DW),
        .DECIM_LOG2(DL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] model_result(input int s);
`ifdef FIR_DECIM_ROUND_EN
        return DW'((s + DECIM / 2) / DECIM);
`else
        return DW'(s / DECIM);
`endif
    endfunction

    // scoreboard monitor: sees the pre-edge state for the upcoming edge
    always @(negedge clk) begin
        if (mon_en && rst === 1'b1) begin
            checks++;
            if (fifo_level !== LW'(exp_q.size())) begin
                errors++;
                $display("FAIL level_track actual=%0d expected=%0d", fifo_level, exp_q.size());
            end
            checks++;
            if (overflow !== exp_ovf) begin
                errors++;
                $display("FAIL overflow_track actual=%b expected=%b", overflow, exp_ovf);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected actual=%h expected=<none>", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        errors++;
                        $display("FAIL pop_data actual=%h expected=%h", out_data, mon_exp);
                    end
                end
            end
        end
    end

    // driver: one clock with the given inputs, then update the bench model
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic fl);
        logic [DW-1:0] res;
        in_valid = v;
        in_data  = d;
        flush    = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            m_acc   = 0;
            m_phase = 0;
        end else if (v) begin
            m_acc += int'(d);
            if (m_phase == DECIM - 1) begin
                res = model_result(m_acc);
                if (exp_q.size() < DEPTH) exp_q.push_back(res);
                else                      exp_ovf = 1'b1;
                m_acc   = 0;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_group_random();
        for (int i = 0; i < DECIM; i++) cycle(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && (exp_q.size() != 0 || out_valid === 1'b1); i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual_valid=%b left=%0d expected empty", out_valid, exp_q.size());
        end
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf actual=%b expected=0", overflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data actual=%h expected=0", out_data); end
        checks++;
        if (fifo_level !== '0) begin errors++; $display("FAIL reset_level actual=%0d expected=0", fifo_level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b expected=0", overflow); end
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cycle(1'b1, 16'd10, 1'b0);
        cycle(1'b1, 16'd20, 1'b0);
        cycle(1'b1, 16'd30, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early actual=%b expected=0", out_valid); end
        cycle(1'b1, 16'd40, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid actual=%b expected=1", out_valid); end
        checks++;
        if (out_data !== 16'd25) begin errors++; $display("FAIL basic_data actual=%0d expected=25", out_data); end
        checks++;
        if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_level actual=%0d expected=1", fifo_level); end
        idle(2);
        checks++;
        if (out_data !== 16'd25) begin errors++; $display("FAIL basic_hold actual=%0d expected=25", out_data); end
        drain();
    endtask

    task automatic test_gapped();
        cycle(1'b1, 16'd100, 1'b0);
        idle(2);
        cycle(1'b1, 16'd200, 1'b0);
        idle(3);
        cycle(1'b1, 16'd300, 1'b0);
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_early actual=%b expected=0", out_valid); end
        cycle(1'b1, 16'd400, 1'b0);
        checks++;
        if (out_data !== 16'd250 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_data actual=%0d/%b expected=250/1", out_data, out_valid);
        end
        drain();
    endtask

    task automatic test_rounding();
        logic [DW-1:0] want;
`ifdef FIR_DECIM_ROUND_EN
        want = 16'd2;
`else
        want = 16'd1;
`endif
        cycle(1'b1, 16'd1, 1'b0);
        cycle(1'b1, 16'd2, 1'b0);
        cycle(1'b1, 16'd2, 1'b0);
        cycle(1'b1, 16'd2, 1'b0);
        checks++;
        if (out_data !== want) begin errors++; $display("FAIL round_small actual=%0d expected=%0d", out_data, want); end
        drain();
        for (int i = 0; i < DECIM; i++) cycle(1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (out_data !== 16'hFFFF) begin errors++; $display("FAIL round_max actual=%h expected=ffff", out_data); end
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int g = 0; g < DEPTH + 1; g++) send_group_random();
        checks++;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level actual=%0d expected=8", fifo_level); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag actual=%b expected=1", overflow); end
        drain();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky actual=%b expected=1", overflow); end
        clear_ovf();
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] second;
        out_ready = 1'b0;
        for (int g = 0; g < DEPTH; g++) send_group_random();
        for (int i = 0; i < DECIM - 1; i++) cycle(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
        second    = exp_q[1];
        out_ready = 1'b1;
        cycle(1'b1, DW'($urandom_range(0, 65535)), 1'b0);
        out_ready = 1'b0;
        checks++;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_level actual=%0d expected=8", fifo_level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf actual=%b expected=0", overflow); end
        checks++;
        if (out_data !== second) begin errors++; $display("FAIL fullpop_head actual=%h expected=%h", out_data, second); end
        drain();
    endtask

    task automatic test_flush();
        cycle(1'b1, 16'd5, 1'b0);
        cycle(1'b1, 16'd7, 1'b0);
        cycle(1'b1, 16'd999, 1'b1);
        cycle(1'b1, 16'd10, 1'b0);
        cycle(1'b1, 16'd20, 1'b0);
        cycle(1'b1, 16'd30, 1'b0);
        cycle(1'b1, 16'd40, 1'b0);
        checks++;
        if (out_data !== 16'd25 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL flush_data actual=%0d/%0d expected=25/1", out_data, fifo_level);
        end
        // flush on the dump sample wins: no push
        cycle(1'b1, 16'd1, 1'b0);
        cycle(1'b1, 16'd1, 1'b0);
        cycle(1'b1, 16'd1, 1'b0);
        cycle(1'b1, 16'd1000, 1'b1);
        idle(1);
        checks++;
        if (fifo_level !== 4'd1) begin errors++; $display("FAIL flush_dump actual=%0d expected=1", fifo_level); end
        for (int i = 0; i < DECIM; i++) cycle(1'b1, 16'd4, 1'b0);
        checks++;
        if (fifo_level !== 4'd2) begin errors++; $display("FAIL flush_after actual=%0d expected=2", fifo_level); end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) send_group_random();
        cycle(1'b1, 16'd500, 1'b0);
        cycle(1'b1, 16'd600, 1'b0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_acc   = 0;
        m_phase = 0;
        exp_ovf = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid actual=%b expected=0", out_valid); end
        checks++;
        if (fifo_level !== '0) begin errors++; $display("FAIL rstmid_level actual=%0d expected=0", fifo_level); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 16'd10, 1'b0);
        cycle(1'b1, 16'd20, 1'b0);
        cycle(1'b1, 16'd30, 1'b0);
        cycle(1'b1, 16'd40, 1'b0);
        checks++;
        if (out_data !== 16'd25 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_fresh actual=%0d/%0d expected=25/1", out_data, fifo_level);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 3) != 0, DW'($urandom_range(0, 65535)), $urandom_range(0, 31) == 0);
        end
        drain();
        clear_ovf();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_rounding();
        test_overflow();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_random();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 16-bit, 32-tap FIR `digital_filter`.
- Consumes the filtered sample stream and decimates it by a power-of-two factor using an accumulate-and-dump average.
- Buffers results in a small FIFO with a valid/ready handshake toward the next consumer (output DMA or serializer).
- Upstream has no backpressure, so loss under FIFO-full is flagged, not stalled.

Parameters:
- DATA_WIDTH, 16: sample width, in and out, unsigned.
- DECIM_LOG2, 2: log2 of the decimation factor; DECIM = 2**DECIM_LOG2; legal range 1..6.
- FIFO_DEPTH, 8: output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  filter output sample is valid this cycle.
- in_data  in  DATA_WIDTH  filter output sample.
- flush  in  1  synchronous; discards the partial accumulation.
- out_valid  out  1  FIFO not empty.
- out_data  out  DATA_WIDTH  FIFO head.
- out_ready  in  1  consumer accepts the head when out_valid=1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky: a result was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, async): accumulator=0, phase=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Accumulator width is DATA_WIDTH+DECIM_LOG2, so it cannot overflow.
- Phase counter counts 0..DECIM-1 and advances only on cycles with in_valid=1.
- Accept, phase<DECIM-1: acc <= acc+in_data; phase <= phase+1.
- Accept, phase=DECIM-1 (dump):
  - sum = acc+in_data; result = sum >> DECIM_LOG2 (truncate).
  - Push result into the FIFO on the same edge.
  - acc <= 0; phase <= 0.
- Push latency: out_valid/out_data reflect the pushed result from the cycle after the dump edge, if the FIFO was empty.
- Pop: on a rising edge with out_valid=1 and out_ready=1. out_data is the registered FIFO head; it holds its value while out_valid=1 and out_ready=0.
- Full FIFO (fifo_level=FIFO_DEPTH) at a dump:
  - If a pop occurs on the same edge, push and pop both succeed; level is unchanged.
  - Otherwise the result is dropped and overflow <= 1.
  - Accumulator/phase reset normally either way.
- Empty FIFO: out_valid=0, so no pop is possible.
  - A push on an empty FIFO becomes visible the next cycle.
  - There is no same-cycle bypass of in_data to out_data.
- flush=1: acc <= 0, phase <= 0; the in_valid sample that cycle is discarded. FIFO contents and overflow are unaffected.
- flush has priority over a dump on the same cycle; no push occurs.
- clr_ovf=1 clears overflow. If a drop happens on the same edge, overflow stays 1 (set wins).
- Reset mid-accumulation or with FIFO occupied: all state cleared immediately, asynchronously. The first post-reset sample is phase 0.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level distinguishes full from empty.
- FIFO state: implicit two-state per entry, via level counter and read/write pointers. No other FSM.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: result = (sum + 2**(DECIM_LOG2-1)) >> DECIM_LOG2, i.e. round-half-up.
  - The maximum sum plus the half-LSB still shifts to at most 2**DATA_WIDTH-1, so no saturation logic is needed.
  - The accumulator stays the same width.
- Undefined: plain truncation, as described in Behaviour.

Test Plan:
- Basic average (DECIM=4):
  - Stimulus: in_valid every cycle with samples 10,20,30,40.
  - Required: out_data=25, out_valid=1 one cycle after the 4th sample edge, fifo_level=1.
- Gapped input:
  - Stimulus: samples 100,200,300,400 with in_valid=0 cycles between them.
  - Required: phase holds across gaps; single output 250.
- Rounding:
  - Stimulus: samples 1,2,2,2 (sum 7).
  - Required: output 1 without FIR_DECIM_ROUND_EN; 2 with it.
  - Also: 0xFFFF x4 -> 0xFFFF in both builds.
- Overflow:
  - Stimulus: out_ready=0; feed 9 full groups (FIFO_DEPTH=8).
  - Required: fifo_level=8, overflow=1, 9th result lost.
  - Then drain with out_ready=1: the 8 original results come out in order.
  - Then clr_ovf -> overflow=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; dump coincides with out_ready=1.
  - Required: level stays 8, no overflow, new result appears last.
- Flush and reset:
  - Stimulus: 2 samples, then flush, then 10,20,30,40.
  - Required: output 25.
  - Then assert rst mid-group with 3 entries queued: out_valid=0, fifo_level=0 immediately.
  - After release, the next 4 samples form a fresh group.
